cnn_relu3_serializer: RTL and testbench

- Consumes the 64-element, 48-bit signed parallel vector produced by the third ReLU stage. Streams it one element per handshake to the next layer (flatten/fully-connected input) over a valid/ready interface.
- Captures a full vector into an internal buffer, then serializes it in index order 0..N_ELEM-1.
- Supports back-to-back frames with no idle cycle between them.

---
 rtl/cnn_relu3_serializer.sv | 139 +++++++++++++
 tb/tb_cnn_relu3_serializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_relu3_serializer.sv
// cnn_relu3_serializer
// Captures the 64-element parallel vector from the third ReLU stage into an
// internal buffer and streams it out one element per valid/ready handshake,
// in index order. A new vector can be accepted on the same edge as the last
// element's handshake, so consecutive frames leave no idle cycle between them.
// Data is carried bit-exact: no arithmetic and no re-application of ReLU.
// IDX_W must equal $clog2(N_ELEM) so that out_idx spans exactly the buffer.

module cnn_relu3_serializer #(
    parameter int N_ELEM = 64,
    parameter int DATA_W = 48,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic signed [DATA_W-1:0] vec_in [0:N_ELEM-1],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  buf_q [0:N_ELEM-1];
    logic signed [DATA_W-1:0]  buf_d [0:N_ELEM-1];
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      out_valid_q, out_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;

    logic                      last_w;
    logic                      fire_w;
    logic                      capture_w;

    // Handshake qualifiers and the upstream ready, derived from registered state.
    always_comb begin
        last_w    = out_valid_q && (idx_q == LAST_IDX);
        fire_w    = out_valid_q && out_ready;
        // Upstream may load either while idle or on the edge that retires the
        // final element, which is what removes the bubble between frames.
        vec_ready = (state_q == S_IDLE) || (fire_w && last_w);
        capture_w = vec_valid && vec_ready;
    end

    // Next-state logic for the IDLE/STREAM controller, buffer, index and counter.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the value.
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                if (capture_w) begin
                    buf_d       = vec_in;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_STREAM;
                end
            end

            S_STREAM: begin
                if (fire_w) begin
                    if (last_w) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                        idx_d        = '0;
                        if (capture_w) begin
                            buf_d       = vec_in;
                            out_valid_d = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge, independent of order.
        if (rst) begin
            state_q      <= S_IDLE;
            // NOTE: the buffer is cleared on reset so out_data never exposes a
            // previous frame's contents after an aborted stream.
            buf_q        <= '{default: '0};
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Output drive: the presented element is always the buffer entry at idx_q.
    always_comb begin
        out_valid  = out_valid_q;
        out_idx    = idx_q;
        out_data   = buf_q[idx_q];
        out_last   = last_w;
        frame_done = frame_done_q;
        frame_cnt  = frame_cnt_q;
    end

endmodule

// File: tb/tb_cnn_relu3_serializer.sv
// Directed testbench for cnn_relu3_serializer. Inputs are driven and outputs
// observed on the falling clock edge; the DUT is built with a 4-bit frame
// counter so the wrap case needs only 16 frames.

module tb_cnn_relu3_serializer;

    localparam int N  = 64;
    localparam int DW = 48;
    localparam int IW = 6;
    localparam int CW = 4;

    // Ready pattern for the backpressure scenario, consumed LSB first: 1,0,0,1,1,0,1,0,...
    localparam logic [15:0] RDY_PAT = 16'b0010_1110_0101_1001;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 vec_valid;
    logic                 vec_ready;
    logic signed [DW-1:0] vec_in [0:N-1];
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic [IW-1:0]        out_idx;
    logic                 out_last;
    logic                 frame_done;
    logic [CW-1:0]        frame_cnt;

    logic signed [DW-1:0] exp_vec [0:N-1];
    logic signed [DW-1:0] exp_b   [0:N-1];
    logic [CW-1:0]        exp_cnt;
    int                   n_pass;
    int                   n_checks;

    cnn_relu3_serializer #(
        .N_ELEM (N),
        .DATA_W (DW),
        .IDX_W  (IW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_in     (vec_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst       = 1'b1;
        vec_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) vec_in[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 4'd0 ||
                vec_ready !== 1'b1 || out_last !== 1'b0 || out_idx !== 6'd0)
                $display("FAIL reset_idle c=%0d: valid=%b done=%b cnt=%0d vrdy=%b last=%b idx=%0d, want 0 0 0 1 0 0",
                         c, out_valid, frame_done, frame_cnt, vec_ready, out_last, out_idx);
            else n_pass++;
        end
    endtask

    task automatic test_single_frame();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            exp_vec[i] = DW'(i * 1000 + 7);
            vec_in[i]  = exp_vec[i];
        end
        out_ready = 1'b1;
        vec_valid = 1'b1;
        #1;
        n_checks++;
        if (vec_ready !== 1'b1) $display("FAIL single_vec_ready: got %b want 1", vec_ready);
        else n_pass++;
        @(negedge clk);
        vec_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(i) || out_data !== exp_vec[i] ||
                out_last !== (i == N - 1) || frame_done !== 1'b0 || vec_ready !== (i == N - 1))
                $display("FAIL single_elem i=%0d: valid=%b idx=%0d data=%0d last=%b done=%b vrdy=%b, want data=%0d",
                         i, out_valid, out_idx, out_data, out_last, frame_done, vec_ready, exp_vec[i]);
            else n_pass++;
            @(negedge clk);
        end
        exp_cnt++;
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== exp_cnt || out_valid !== 1'b0 || out_idx !== 6'd0)
            $display("FAIL single_done: done=%b cnt=%0d valid=%b idx=%0d, want 1 %0d 0 0",
                     frame_done, frame_cnt, out_valid, out_idx, exp_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || vec_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL single_after: done=%b vrdy=%b valid=%b, want 0 1 0", frame_done, vec_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int exp_idx;
        for (int i = 0; i < N; i++) begin
            exp_vec[i] = DW'(i * 1000 + 7);
            vec_in[i]  = exp_vec[i];
        end
        out_ready = 1'b0;
        vec_valid = 1'b1;
        exp_idx   = 0;
        for (int c = 0; c < 1000 && exp_idx < N; c++) begin
            @(negedge clk);
            if (c == 0) vec_valid = 1'b0;
            out_ready = RDY_PAT[c % 16];
            #1;
            // Stalled or not, the presented element must be the next one not yet taken.
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(exp_idx) || out_data !== exp_vec[exp_idx] ||
                vec_ready !== (out_ready && exp_idx == N - 1) || frame_done !== 1'b0)
                $display("FAIL bp_elem c=%0d rdy=%b: valid=%b idx=%0d data=%0d vrdy=%b done=%b, want idx=%0d data=%0d",
                         c, out_ready, out_valid, out_idx, out_data, vec_ready, frame_done, exp_idx, exp_vec[exp_idx]);
            else n_pass++;
            if (out_ready) exp_idx++;
        end
        n_checks++;
        if (exp_idx != N) $display("FAIL bp_timeout: got %0d elements want %0d", exp_idx, N);
        else n_pass++;
        @(negedge clk);
        exp_cnt++;
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== exp_cnt || out_valid !== 1'b0)
            $display("FAIL bp_done: done=%b cnt=%0d valid=%b, want 1 %0d 0", frame_done, frame_cnt, out_valid, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_seen;
        logic signed [DW-1:0] want;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            exp_vec[i] = DW'(i);
            exp_b[i]   = DW'(-(i + 1));
            vec_in[i]  = exp_vec[i];
        end
        out_ready = 1'b1;
        vec_valid = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            if (k == 0 || k == N) vec_valid = 1'b0;
            want = (k < N) ? exp_vec[k] : exp_b[k - N];
            if (frame_done === 1'b1) done_seen++;
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(k % N) || out_data !== want ||
                out_last !== (k % N == N - 1) || frame_done !== (k == N) ||
                vec_ready !== (k % N == N - 1))
                $display("FAIL b2b_elem k=%0d: valid=%b idx=%0d data=%h last=%b done=%b vrdy=%b, want data=%h done=%b",
                         k, out_valid, out_idx, out_data, out_last, frame_done, vec_ready, want, (k == N));
            else n_pass++;
            if (k == N) begin
                n_checks++;
                if (frame_cnt !== exp_cnt + 4'd1)
                    $display("FAIL b2b_cnt_a: got %0d want %0d", frame_cnt, exp_cnt + 4'd1);
                else n_pass++;
            end
            if (k == N / 2) begin
                for (int i = 0; i < N; i++) vec_in[i] = exp_b[i];
                vec_valid = 1'b1;
            end
        end
        @(negedge clk);
        if (frame_done === 1'b1) done_seen++;
        exp_cnt = exp_cnt + 4'd2;
        n_checks++;
        if (done_seen != 2 || frame_cnt !== exp_cnt || out_valid !== 1'b0)
            $display("FAIL b2b_end: pulses=%0d cnt=%0d valid=%b, want 2 %0d 0", done_seen, frame_cnt, out_valid, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            exp_vec[i] = DW'(i * 3 + 1);
            vec_in[i]  = exp_vec[i];
        end
        out_ready = 1'b1;
        vec_valid = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (c == 0) vec_valid = 1'b0;
            if (out_idx === 6'd30) found = 1'b1;
        end
        n_checks++;
        if (!found || out_data !== exp_vec[30])
            $display("FAIL rmid_reach30: found=%b data=%0d want data=%0d", found, out_data, exp_vec[30]);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = '0;
        n_checks++;
        if (out_valid !== 1'b0 || out_idx !== 6'd0 || frame_cnt !== 4'd0 || frame_done !== 1'b0)
            $display("FAIL rmid_reset: valid=%b idx=%0d cnt=%0d done=%b, want 0 0 0 0",
                     out_valid, out_idx, frame_cnt, frame_done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || out_valid !== 1'b0 || vec_ready !== 1'b1)
            $display("FAIL rmid_after: done=%b valid=%b vrdy=%b, want 0 0 1", frame_done, out_valid, vec_ready);
        else n_pass++;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(i) || out_data !== exp_vec[i] || frame_done !== 1'b0)
                $display("FAIL rmid_fresh i=%0d: valid=%b idx=%0d data=%0d done=%b, want data=%0d",
                         i, out_valid, out_idx, out_data, frame_done, exp_vec[i]);
            else n_pass++;
            @(negedge clk);
        end
        exp_cnt++;
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== exp_cnt)
            $display("FAIL rmid_fresh_done: done=%b cnt=%0d, want 1 %0d", frame_done, frame_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        int errs;
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_cnt   = '0;
        out_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < N; i++) vec_in[i] = DW'(f * N + i);
            vec_valid = 1'b1;
            @(negedge clk);
            vec_valid = 1'b0;
            errs = 0;
            for (int j = 0; j < N; j++) begin
                if (out_valid !== 1'b1 || out_idx !== IW'(j) || out_data !== DW'(f * N + j) ||
                    frame_done !== 1'b0) errs++;
                @(negedge clk);
            end
            exp_cnt++;
            n_checks++;
            if (errs != 0 || frame_done !== 1'b1 || frame_cnt !== exp_cnt)
                $display("FAIL wrap_frame f=%0d: bad_cycles=%0d done=%b cnt=%0d, want 0 1 %0d",
                         f, errs, frame_done, frame_cnt, exp_cnt);
            else n_pass++;
        end
        n_checks++;
        if (frame_cnt !== 4'd0) $display("FAIL wrap_zero: cnt=%0d want 0", frame_cnt);
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
